// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and sequencer state type for the UART feeder (watchdog option UART_FEED_WATCHDOG_EN).
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int WD_LIMIT = 8;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE} seq_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous FIFO with registered full/empty flags and wrap-bit pointers.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic wr_en, rd_en;
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign wr_nxt = wr_ptr + (AW+1)'(wr_en);
  assign rd_nxt = rd_ptr + (AW+1)'(rd_en);
  assign dout = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  // full tracks the next pointers exactly; empty sees pops at once but pushes one edge late
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty <= (wr_ptr == rd_nxt);
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus send sequencer paced by the transmitter busy flag.
// Define UART_FEED_WATCHDOG_EN to add the stuck-transmitter watchdog and watchdog_err output.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              send_trigger,
  input  logic              tx_busy,
  output logic [AW:0]       fifo_count,
  output logic              idle
`ifdef UART_FEED_WATCHDOG_EN
  ,
  output logic              watchdog_err
`endif
);
  seq_state_t state, next;
  logic full, empty, pop, wd_trip;
  logic [BYTE_W-1:0] head;
  assign in_ready = !full;
  uart_byte_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(in_valid && in_ready),
    .pop(pop),
    .din(in_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
`ifdef UART_FEED_WATCHDOG_EN
  logic [3:0] wd_cnt;
  assign wd_trip = (state == S_WAIT_BUSY) && !tx_busy && (wd_cnt == 4'(WD_LIMIT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_cnt <= '0;
      watchdog_err <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT_BUSY && !tx_busy) ? wd_cnt + 4'd1 : 4'd0;
      watchdog_err <= watchdog_err | wd_trip;
    end
`else
  assign wd_trip = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = S_IDLE;
    case (state)
      S_IDLE:      next = (!empty && !tx_busy) ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    next = S_WAIT_BUSY;
      S_WAIT_BUSY: next = tx_busy ? S_WAIT_DONE : (wd_trip ? S_IDLE : S_WAIT_BUSY);
      S_WAIT_DONE: next = tx_busy ? S_WAIT_DONE : S_IDLE;
      default:     next = S_IDLE;
    endcase
  end
  always_comb begin
    pop = (state == S_IDLE) && (next == S_LAUNCH);
    idle = (fifo_count == '0) && (state == S_IDLE) && !tx_busy;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      send_trigger <= 1'b0;
      tx_data <= '0;
    end else begin
      send_trigger <= (next == S_LAUNCH);
      if (pop) tx_data <= head;
    end
endmodule
